// File: rtl/frontend_read_return.sv
// Read-return frontend: tracks issued read tags in order and serialises each
// returned 1024-bit line into four 256-bit beats tagged with its id/core.
module frontend_read_return #(
  parameter int TAG_DEPTH = 8,
  parameter int ID_W      = 4,
  parameter int CORE_W    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_read_issue_valid,
  input  logic [ID_W-1:0]   i_read_issue_id,
  input  logic [CORE_W-1:0] i_read_issue_core,
  output logic              o_tag_full,
  output logic              o_frontend_receive_ready,
  input  logic              i_returned_data_valid,
  input  logic [1023:0]     i_returned_data,
  input  logic              i_interconnection_ready,
  output logic              o_scheduler_request_valid,
  output logic [255:0]      o_scheduler_read_data,
  output logic              o_scheduler_read_data_last,
  output logic [ID_W-1:0]   o_scheduler_request_id,
  output logic [CORE_W-1:0] o_scheduler_core_num,
  output logic              o_tag_overflow_err,
  output logic              o_orphan_data_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  state_t             next_state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ID_W-1:0]    id_mem   [TAG_DEPTH];
  logic [CORE_W-1:0]  core_mem [TAG_DEPTH];
  logic [1023:0]      line_buf;
  logic [1:0]         beat;
  logic [ID_W-1:0]    line_id;
  logic [CORE_W-1:0]  line_core;
  logic               fifo_empty;
  logic               fifo_full;
  logic               beat_fire;
  logic               pop;
  logic               push;
  logic               capture;
  logic               orphan;

  // Orphan/capture decisions use the registered (pre-push) occupancy, so a tag
  // pushed in the same cycle can never be paired with the line arriving then.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
  assign beat_fire  = (state == SEND) && i_interconnection_ready;
  assign pop        = beat_fire && (beat == 2'd3);
  assign push       = i_read_issue_valid && (!fifo_full || pop);
  assign capture    = (state == IDLE) && i_returned_data_valid && !fifo_empty;
  assign orphan     = (state == IDLE) && i_returned_data_valid && fifo_empty;

  assign o_tag_full = fifo_full;

  always_ff @(posedge i_clk) begin
    if (push) begin
      id_mem[wr_ptr]   <= i_read_issue_id;
      core_mem[wr_ptr] <= i_read_issue_core;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture) next_state = SEND;
      SEND:    if (pop)     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_frontend_receive_ready   = (state == IDLE);
    o_scheduler_request_valid  = (state == SEND);
    o_scheduler_read_data_last = (state == SEND) && (beat == 2'd3);
  end

  // Beat counter parks on 3 after the last handshake so data holds in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_buf  <= '0;
      beat      <= '0;
      line_id   <= '0;
      line_core <= '0;
    end else if (capture) begin
      line_buf  <= i_returned_data;
      beat      <= '0;
      line_id   <= id_mem[rd_ptr];
      line_core <= core_mem[rd_ptr];
    end else if (beat_fire && (beat != 2'd3)) begin
      beat <= beat + 1'b1;
    end
  end

  always_comb begin
    o_scheduler_read_data = line_buf[255:0];
    case (beat)
      2'd0:    o_scheduler_read_data = line_buf[255:0];
      2'd1:    o_scheduler_read_data = line_buf[511:256];
      2'd2:    o_scheduler_read_data = line_buf[767:512];
      default: o_scheduler_read_data = line_buf[1023:768];
    endcase
  end

  assign o_scheduler_request_id = line_id;
  assign o_scheduler_core_num   = line_core;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tag_overflow_err <= 1'b0;
      o_orphan_data_err  <= 1'b0;
    end else begin
      if (i_read_issue_valid && fifo_full && !pop) o_tag_overflow_err <= 1'b1;
      if (orphan)                                   o_orphan_data_err  <= 1'b1;
    end
  end

endmodule
